// File: rtl/lru_arbiter.sv
// rtl/lru_arbiter.sv - least-recently-used arbiter sharing one resource among N requesters
//
// Ports:
//   clk      - system clock; all state updates on posedge
//   rst      - synchronous active-high reset
//   req      - request vector; bit i = requester i wants the resource
//   done     - current owner releases the resource (ignored when idle)
//   grant    - registered one-hot grant, all-zero when idle
//   grant_id - index of current owner, 0 when idle
//   busy     - high while any grant bit is high
//   expired  - one-cycle pulse on the cycle a grant is removed by the hold timeout
//   lru_id   - ID currently at the least-recent end of the recency list

module lru_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 expired,
  output logic [$clog2(N)-1:0] lru_id
);

  localparam int IW = $clog2(N);
  // Wide enough to hold HOLD_MAX-1 even when HOLD_MAX is a power of two.
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_n;
  logic [N-1:0]  grant_n;
  logic [IW-1:0] grant_id_n;
  logic          expired_n;

  // order[0] is most recently granted, order[N-1] least recently granted.
  logic [IW-1:0] order   [N];
  logic [IW-1:0] order_n [N];

  logic [IW-1:0] win_id;
  logic [IW-1:0] win_pos;
  logic          rel_done;
  logic          rel_drop;
  logic          rel_timeout;

  // Winner search: scanning from MRU towards LRU, the last requesting entry
  // seen is the least recently granted one.
  always_comb begin
    win_id  = '0;
    win_pos = '0;
    for (int k = 0; k < N; k++) begin
      if (req[order[k]]) begin
        win_id  = order[k];
        win_pos = IW'(k);
      end
    end
  end

  assign rel_done    = done;
  assign rel_drop    = ~req[grant_id];
  assign rel_timeout = (hold == HW'(HOLD_MAX - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    hold_n     = hold;
    grant_n    = grant;
    grant_id_n = grant_id;
    expired_n  = 1'b0;
    for (int k = 0; k < N; k++) begin
      order_n[k] = order[k];
    end

    case (state)
      IDLE: begin
        if (|req) begin
          state_n    = GRANT;
          grant_n    = N'(1) << win_id;
          grant_id_n = win_id;
          hold_n     = '0;
          // Winner moves to the MRU slot; entries that were more recent than
          // it slide one place towards LRU, older entries stay put.
          for (int k = 0; k < N; k++) begin
            if (k == 0) begin
              order_n[k] = win_id;
            end else if (k <= int'(win_pos)) begin
              order_n[k] = order[k-1];
            end
          end
        end
      end

      GRANT: begin
        if (rel_done || rel_drop || rel_timeout) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
          hold_n     = '0;
          // A voluntary release wins over the timeout.
          expired_n  = rel_timeout & ~rel_done & ~rel_drop;
        end else begin
          hold_n = hold + HW'(1);
        end
      end

      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        grant_id_n = '0;
        hold_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
      lru_id   <= '0;
      for (int k = 0; k < N; k++) begin
        order[k] <= IW'(N - 1 - k);
      end
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      busy     <= |grant_n;
      expired  <= expired_n;
      lru_id   <= order_n[N-1];
      for (int k = 0; k < N; k++) begin
        order[k] <= order_n[k];
      end
    end
  end

endmodule

// File: tb/tb_lru_arbiter.sv
// tb/tb_lru_arbiter.sv - scoreboard testbench for lru_arbiter

module tb_lru_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 8;
  localparam int IW       = $clog2(N);

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          expired;
  logic [IW-1:0] lru_id;

  lru_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .expired  (expired),
    .lru_id   (lru_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  grant;
    logic [IW-1:0] gid;
    logic          busy;
    logic          expd;
    logic [IW-1:0] lru;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: recency list as a queue, front = most recent.
  int mq[$];
  bit m_busy;
  int m_owner;
  int m_hold;
  bit m_exp;

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic d,
                            output exp_t e);
    int wp;
    int w;
    bit drop;
    if (r) begin
      mq.delete();
      for (int k = 0; k < N; k++) mq.push_back(N - 1 - k);
      m_busy = 0; m_owner = 0; m_hold = 0; m_exp = 0;
    end else if (!m_busy) begin
      m_exp = 0;
      if (rq != '0) begin
        wp = -1;
        for (int k = N - 1; k >= 0; k--)
          if (wp < 0 && rq[mq[k]]) wp = k;
        w = mq[wp];
        mq.delete(wp);
        mq.push_front(w);
        m_busy = 1; m_owner = w; m_hold = 0;
      end
    end else begin
      drop = !rq[m_owner];
      if (d || drop || m_hold == HOLD_MAX - 1) begin
        m_exp = !d && !drop;
        m_busy = 0; m_owner = 0; m_hold = 0;
      end else begin
        m_hold++;
        m_exp = 0;
      end
    end
    e.grant = m_busy ? (N'(1) << m_owner) : '0;
    e.gid   = IW'(m_owner);
    e.busy  = m_busy;
    e.expd  = m_exp;
    e.lru   = IW'(mq[N-1]);
    e.cyc   = cyc;
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rq, input logic d);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    cyc++;
    model_step(r, rq, d, e);
    exp_q.push_back(e);
  endtask

  // Monitor: compares every registered output sample against the scoreboard
  // and checks structural properties of the grant stream.
  bit           capture = 0;
  int           seen_ids[$];
  logic [N-1:0] prev_grant = '0;
  int           run_len = 0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (grant !== e.grant || grant_id !== e.gid || busy !== e.busy ||
            expired !== e.expd || lru_id !== e.lru) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d: got grant=%b id=%0d busy=%b exp=%b lru=%0d want grant=%b id=%0d busy=%b exp=%b lru=%0d",
                   e.cyc, grant, grant_id, busy, expired, lru_id,
                   e.grant, e.gid, e.busy, e.expd, e.lru);
        end
      end
      n_cmp++;
      if ($countones(grant) > 1) begin
        n_fail++;
        $display("FAIL onehot: got grant=%b want at most one bit", grant);
      end
      if (prev_grant != '0 && grant != '0) begin
        n_cmp++;
        if (grant !== prev_grant) begin
          n_fail++;
          $display("FAIL gap: got handoff %b -> %b want idle cycle between", prev_grant, grant);
        end
      end
      if (grant != '0) run_len++;
      if (prev_grant != '0 && grant == '0) begin
        n_cmp++;
        if (run_len > HOLD_MAX) begin
          n_fail++;
          $display("FAIL hold_len: got %0d cycles want <= %0d", run_len, HOLD_MAX);
        end
        run_len = 0;
      end
      if (grant == '0) run_len = 0;
      if (capture && prev_grant == '0 && grant != '0) seen_ids.push_back(int'(grant_id));
      prev_grant = grant;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    int exp_ids[5];
    logic [N-1:0] rq;
    rst = 1'b1; req = '0; done = 1'b0;
    exp_ids = '{0, 1, 2, 3, 0};

    // Round-robin-like rotation under constant full request.
    drive(1, '0, 0);
    drive(1, '0, 0);
    capture = 1;
    repeat (45) drive(0, 4'b1111, 0);
    capture = 0;
    n_cmp++;
    if (seen_ids.size() != 5) begin
      n_fail++;
      $display("FAIL rotation_count: got %0d grants want 5", seen_ids.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (seen_ids[i] != exp_ids[i]) begin
          n_fail++;
          $display("FAIL rotation[%0d]: got id %0d want %0d", i, seen_ids[i], exp_ids[i]);
        end
      end
    end
    drive(0, '0, 0);
    drive(0, '0, 0);

    // Single pulse request from ID 2, then release by dropped request.
    drive(1, '0, 0);
    drive(0, 4'b0100, 0);
    drive(0, '0, 0);
    drive(0, '0, 0);

    // ID 1 releases with done after 3 held cycles, then 0 and 1 compete.
    drive(1, '0, 0);
    repeat (4) drive(0, 4'b0010, 0);
    drive(0, 4'b0010, 1);
    repeat (4) drive(0, 4'b0011, 0);
    drive(0, '0, 0);

    // done coincides with the timeout.
    drive(1, '0, 0);
    repeat (8) drive(0, 4'b0001, 0);
    drive(0, 4'b0001, 1);
    drive(0, '0, 0);
    drive(0, '0, 0);

    // Reset in the middle of a grant held by ID 3.
    drive(1, '0, 0);
    repeat (6) drive(0, 4'b1000, 0);
    drive(1, 4'b1000, 0);
    drive(0, 4'b1000, 0);
    drive(0, 4'b1000, 0);
    drive(0, '0, 0);

    // Randomized traffic with sticky requests so timeouts occur.
    rq = '0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, (1 << N) - 1));
      drive(($urandom_range(0, 499) == 0), rq, ($urandom_range(0, 9) == 0));
    end
    drive(0, '0, 0);

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
